// File: rtl/inst_queue.sv
// Instruction fetch queue between the PC stage and the decode stage.
// Issues one fetch per free slot, stores in-order memory responses, and
// presents the oldest fetched instruction to the consumer. A flush empties
// the queue and silently discards responses still in flight.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   pc_value                 current fetch address from the PC stage
//   need_insert              PC advance strobe (same as imem_req)
//   imem_req/imem_addr       fetch request and address to instruction memory
//   imem_valid/imem_data     in-order memory response
//   flush                    discard all queued and in-flight instructions
//   inst_valid/inst_out/inst_pc  head instruction towards the consumer
//   inst_ready               consumer accepts the head this cycle
//
// Optional feature: define INST_QUEUE_BYPASS_EN to forward a response straight
// to the outputs when the queue holds no fetched instruction.
module inst_queue #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc_value,
    output logic                  need_insert,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_valid,
    input  logic [INST_WIDTH-1:0] imem_data,
    input  logic                  flush,
    output logic                  inst_valid,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready
);

    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PTR_W  = IDX_W + 1;
    // Drops can accumulate across back-to-back flushes, so leave headroom.
    localparam int unsigned DROP_W = PTR_W + 3;

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      fill_q, fill_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [DROP_W-1:0]     drop_cnt_q, drop_cnt_d;
    logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];
    logic [INST_WIDTH-1:0] inst_q [DEPTH];
    logic [DEPTH-1:0]      filled_q;

    logic [IDX_W-1:0] head_idx, fill_idx, tail_idx;
    logic [PTR_W-1:0] occupancy, pending;
    logic             resp_ok, stored_valid, bypass, byp_take;
    logic             do_pop, do_fill, do_drop, flush_resp;

    assign head_idx  = head_q[IDX_W-1:0];
    assign fill_idx  = fill_q[IDX_W-1:0];
    assign tail_idx  = tail_q[IDX_W-1:0];
    assign occupancy = tail_q - head_q;
    assign pending   = tail_q - fill_q;

    // Fetch request: occupancy uses the registered head, so a pop frees a slot next cycle.
    assign imem_req    = !reset && !flush && (occupancy < PTR_W'(DEPTH));
    assign need_insert = imem_req;
    assign imem_addr   = pc_value;

    // A response is usable only when it is not owed to a pre-flush request
    // and some request is actually outstanding (stray responses are ignored).
    assign resp_ok      = imem_valid && !flush && (drop_cnt_q == '0) && (pending != '0);
    assign stored_valid = (head_q != fill_q) && filled_q[head_idx];

`ifdef INST_QUEUE_BYPASS_EN
    assign bypass = resp_ok && (head_q == fill_q);
`else
    assign bypass = 1'b0;
`endif

    // Head presentation: stored entry first, otherwise the forwarded response.
    always_comb begin
        inst_valid = 1'b0;
        inst_out   = '0;
        inst_pc    = '0;
        if (!reset && !flush) begin
            if (stored_valid) begin
                inst_valid = 1'b1;
                inst_out   = inst_q[head_idx];
                inst_pc    = pc_q[head_idx];
            end else if (bypass) begin
                inst_valid = 1'b1;
                inst_out   = imem_data;
                inst_pc    = pc_q[fill_idx];
            end
        end
    end

    assign do_pop     = inst_valid && inst_ready;
    assign byp_take   = bypass && inst_ready;
    assign do_fill    = resp_ok && !byp_take;
    assign do_drop    = imem_valid && !flush && (drop_cnt_q != '0);
    assign flush_resp = imem_valid && ((drop_cnt_q != '0) || (pending != '0));

    // Pointer and drop-counter next state.
    always_comb begin
        head_d     = head_q;
        fill_d     = fill_q;
        tail_d     = tail_q;
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            head_d     = '0;
            fill_d     = '0;
            tail_d     = '0;
            // Every request still owed a response becomes a drop, less the one arriving now.
            drop_cnt_d = drop_cnt_q + DROP_W'(pending) - DROP_W'(flush_resp);
        end else begin
            if (do_pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (do_fill || byp_take) begin
                fill_d = fill_q + PTR_W'(1);
            end
            if (imem_req) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (do_drop) begin
                drop_cnt_d = drop_cnt_q - DROP_W'(1);
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q     <= '0;
            fill_q     <= '0;
            tail_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            head_q     <= head_d;
            fill_q     <= fill_d;
            tail_q     <= tail_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Entry storage. Tail and fill slots never coincide: a request needs a
    // free slot, and a fill needs an outstanding request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filled_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
        end else begin
            if (imem_req) begin
                pc_q[tail_idx]     <= pc_value;
                filled_q[tail_idx] <= 1'b0;
            end
            if (do_fill) begin
                inst_q[fill_idx]   <= imem_data;
                filled_q[fill_idx] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: scenario tasks plus a randomized run against a
// queue-based reference model and an in-order instruction memory model.
module tb_inst_queue;

    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush, imem_valid, inst_ready;
    logic [AW-1:0] pc_value, imem_addr, inst_pc;
    logic [IW-1:0] imem_data, inst_out;
    logic          need_insert, imem_req, inst_valid;

    inst_queue #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_value   (pc_value),
        .need_insert(need_insert),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .flush      (flush),
        .inst_valid (inst_valid),
        .inst_out   (inst_out),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: queued entries in program order, plus pending drops.
    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] inst;
        bit            filled;
    } ent_t;
    ent_t mq[$];
    int   drop = 0;

    // Instruction memory: in-order responses, each no earlier than its due cycle.
    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] data;
        int            due;
    } mreq_t;
    mreq_t memq[$];
    int    mem_lat_min = 1;
    int    mem_lat_max = 1;
    bit    mem_stall   = 1'b0;
    bit    mem_fire    = 1'b0;

    bit            exp_req, exp_valid, exp_byp, exp_fill;
    logic [IW-1:0] exp_out;
    logic [AW-1:0] exp_pc;
    bit            s_flush, s_valid, s_ready, s_req_dut, s_ni_dut;
    logic [IW-1:0] s_data;
    logic [AW-1:0] s_pcv, s_addr;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int n_filled();
        int n = 0;
        foreach (mq[i]) if (mq[i].filled) n++;
        return n;
    endfunction

    task automatic mem_drive();
        mem_fire   = 1'b0;
        imem_valid = 1'b0;
        imem_data  = $urandom();
        if (memq.size() > 0 && memq[0].due <= cyc &&
            !(mem_stall && $urandom_range(3, 0) == 0)) begin
            mem_fire   = 1'b1;
            imem_valid = 1'b1;
            imem_data  = memq[0].data;
        end
    endtask

    // Expected outputs for the current cycle from the model and current inputs.
    task automatic model_eval();
        int nf;
        nf        = n_filled();
        exp_req   = !reset && !flush && (mq.size() < DEPTH);
        exp_fill  = !flush && imem_valid && (drop == 0) && (nf < mq.size());
        exp_byp   = 1'b0;
        exp_valid = 1'b0;
        exp_out   = '0;
        exp_pc    = '0;
        if (!flush && !reset) begin
            if (nf > 0) begin
                exp_valid = 1'b1;
                exp_out   = mq[0].inst;
                exp_pc    = mq[0].pc;
            end
`ifdef INST_QUEUE_BYPASS_EN
            else if (exp_fill) begin
                exp_valid = 1'b1;
                exp_byp   = 1'b1;
                exp_out   = imem_data;
                exp_pc    = mq[0].pc;
            end
`endif
        end
        s_flush   = flush;
        s_valid   = imem_valid;
        s_ready   = inst_ready;
        s_data    = imem_data;
        s_pcv     = pc_value;
        s_addr    = imem_addr;
        s_req_dut = imem_req;
        s_ni_dut  = need_insert;
    endtask

    // Clock edge: update model, memory and PC stage from the sampled cycle.
    task automatic advance();
        int    nf;
        int    outst;
        bit    pop;
        ent_t  e;
        mreq_t mr;
        nf  = n_filled();
        pop = exp_valid && s_ready;
        @(posedge clk);
        #1;
        cyc++;
        flush = 1'b0;
        if (s_flush) begin
            outst = drop + (mq.size() - nf);
            if (s_valid && outst > 0) outst--;
            drop = outst;
            mq.delete();
        end else begin
            if (exp_fill && !(exp_byp && pop)) begin
                mq[nf].inst   = s_data;
                mq[nf].filled = 1'b1;
            end
            if (pop) void'(mq.pop_front());
            if (s_valid && drop > 0) drop--;
            if (exp_req) begin
                e.pc     = s_pcv;
                e.inst   = '0;
                e.filled = 1'b0;
                mq.push_back(e);
            end
        end
        if (mem_fire) void'(memq.pop_front());
        if (s_req_dut) begin
            mr.pc   = s_addr;
            mr.data = mem_word(s_addr);
            mr.due  = cyc - 1 + int'($urandom_range(mem_lat_max, mem_lat_min));
            memq.push_back(mr);
        end
        if (s_ni_dut) pc_value = pc_value + AW'(4);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        flush      = 1'b0;
        inst_ready = 1'b0;
        imem_valid = 1'b0;
        imem_data  = '0;
        pc_value   = '0;
        mem_fire   = 1'b0;
        memq.delete();
        mq.delete();
        drop = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        flush = 1'b0; inst_ready = 1'b0; imem_valid = 1'b0; imem_data = '0; pc_value = '0;
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
        n_cmp++; if (need_insert !== 1'b0) begin n_fail++; $display("FAIL rst_need_insert: got %b want 0", need_insert); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
        n_cmp++; if (inst_out !== '0) begin n_fail++; $display("FAIL rst_out: got %h want 0", inst_out); end
        n_cmp++; if (inst_pc !== '0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", inst_pc); end
        do_reset();
        mem_lat_min = 1; mem_lat_max = 1; mem_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_drive(); #1; model_eval(); advance();
        end
        mem_drive();
        #1;
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
            n_fail++; $display("FAIL pre_async_head: valid=%b pc=%h want 1/0", inst_valid, inst_pc);
        end
        reset = 1'b1;
        #1;
        n_cmp++; if (imem_req !== 1'b0 || need_insert !== 1'b0) begin
            n_fail++; $display("FAIL async_rst_req: req=%b ni=%b want 0/0", imem_req, need_insert);
        end
        n_cmp++; if (inst_valid !== 1'b0 || inst_out !== '0 || inst_pc !== '0) begin
            n_fail++; $display("FAIL async_rst_head: valid=%b out=%h pc=%h want 0", inst_valid, inst_out, inst_pc);
        end
        do_reset();
    endtask

    // Reset, latency 1, consumer stalled: four requests then full.
    task automatic test_fill_to_full();
        do_reset();
        mem_lat_min = 1; mem_lat_max = 1; mem_stall = 1'b0; inst_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mem_drive(); #1; model_eval();
            n_cmp++; if (need_insert !== (i < 4)) begin
                n_fail++; $display("FAIL fill_need_insert[%0d]: got %b want %b", i, need_insert, (i < 4));
            end
            if (i < 4) begin
                n_cmp++; if (imem_addr !== AW'(4 * i)) begin
                    n_fail++; $display("FAIL fill_addr[%0d]: got %h want %h", i, imem_addr, 4 * i);
                end
            end
            advance();
        end
    endtask

    // From full: one pop, slot visible the following cycle, then ordered drain.
    task automatic test_single_pop();
        inst_ready = 1'b1;
        mem_drive(); #1; model_eval();
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_out !== mem_word(32'h0)) begin
            n_fail++; $display("FAIL pop_head: valid=%b pc=%h out=%h want pc 0", inst_valid, inst_pc, inst_out);
        end
        n_cmp++; if (need_insert !== 1'b0) begin n_fail++; $display("FAIL pop_same_cycle_req: got %b want 0", need_insert); end
        advance();
        inst_ready = 1'b0;
        mem_drive(); #1; model_eval();
        n_cmp++; if (need_insert !== 1'b1 || imem_addr !== 32'h10) begin
            n_fail++; $display("FAIL pop_next_req: ni=%b addr=%h want 1/10", need_insert, imem_addr);
        end
        n_cmp++; if (inst_pc !== 32'h4) begin n_fail++; $display("FAIL pop_next_head: got %h want 4", inst_pc); end
        advance();
        mem_drive(); #1; model_eval();
        n_cmp++; if (need_insert !== 1'b0) begin n_fail++; $display("FAIL pop_refull: got %b want 0", need_insert); end
        advance();
        inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_drive(); #1; model_eval();
            n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== AW'(4 + 4 * k) || inst_out !== mem_word(AW'(4 + 4 * k))) begin
                n_fail++; $display("FAIL drain[%0d]: valid=%b pc=%h out=%h want pc %h", k, inst_valid, inst_pc, inst_out, 4 + 4 * k);
            end
            advance();
        end
    endtask

    // Flush with two requests in flight: both responses dropped, third fills.
    task automatic test_flush();
        int seen;
        bit got;
        do_reset();
        mem_lat_min = 3; mem_lat_max = 3; mem_stall = 1'b0; inst_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_drive(); #1; model_eval(); advance();
        end
        flush = 1'b1;
        pc_value = 32'h100;
        mem_drive(); #1; model_eval();
        n_cmp++; if (imem_req !== 1'b0 || need_insert !== 1'b0 || inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_cycle: req=%b ni=%b valid=%b want 0", imem_req, need_insert, inst_valid);
        end
        advance();
        seen = 0;
        got  = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            mem_drive(); #1; model_eval();
            if (inst_valid === 1'b1) begin
                got = 1'b1;
                n_cmp++; if (inst_pc !== 32'h100 || inst_out !== mem_word(32'h100)) begin
                    n_fail++; $display("FAIL flush_first: pc=%h out=%h want 100/%h", inst_pc, inst_out, mem_word(32'h100));
                end
`ifdef INST_QUEUE_BYPASS_EN
                n_cmp++; if (seen !== 2) begin n_fail++; $display("FAIL flush_drops: responses before=%0d want 2", seen); end
`else
                n_cmp++; if (seen !== 3) begin n_fail++; $display("FAIL flush_drops: responses before=%0d want 3", seen); end
`endif
            end
            if (mem_fire) seen++;
            advance();
        end
        if (!got) begin
            n_cmp++; n_fail++; $display("FAIL flush_timeout: no valid instruction after flush");
        end
    endtask

    // Consumer always ready: request, fill and pop together; 9 ordered deliveries.
    task automatic test_back_to_back();
        int pops;
        do_reset();
        mem_lat_min = 1; mem_lat_max = 1; mem_stall = 1'b0; inst_ready = 1'b1;
        mem_fire = 1'b0; imem_valid = 1'b1; imem_data = 32'h0000_0BAD;
        #1; model_eval();
        n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL stray_resp: valid=%b want 0", inst_valid); end
        advance();
        pops = 0;
        for (int j = 0; j < 20 && pops < 9; j++) begin
            mem_drive(); #1; model_eval();
            if (j >= 1) begin
                n_cmp++; if (inst_valid !== 1'b1 || need_insert !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_steady[%0d]: valid=%b ni=%b want 1/1", j, inst_valid, need_insert);
                end
            end
            if (inst_valid === 1'b1) begin
                n_cmp++; if (inst_pc !== AW'(4 * pops) || inst_out !== mem_word(AW'(4 * pops))) begin
                    n_fail++; $display("FAIL b2b_order[%0d]: pc=%h out=%h want pc %h", pops, inst_pc, inst_out, 4 * pops);
                end
                pops++;
            end
            advance();
        end
        n_cmp++; if (pops !== 9) begin n_fail++; $display("FAIL b2b_count: got %0d want 9", pops); end
    endtask

    // Response into an empty queue: same cycle with forwarding, else one cycle later.
    task automatic test_bypass();
        do_reset();
        mem_lat_min = 1; mem_lat_max = 1; mem_stall = 1'b0; inst_ready = 1'b1;
        mem_drive(); #1; model_eval(); advance();
        if (memq.size() > 0) memq[0].data = 32'hDEAD_BEEF;
        mem_drive(); #1; model_eval();
`ifdef INST_QUEUE_BYPASS_EN
        n_cmp++; if (inst_valid !== 1'b1 || inst_out !== 32'hDEAD_BEEF || inst_pc !== 32'h0) begin
            n_fail++; $display("FAIL bypass_same_cycle: valid=%b out=%h pc=%h want 1/deadbeef/0", inst_valid, inst_out, inst_pc);
        end
        advance();
`else
        n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL nobypass_same_cycle: valid=%b want 0", inst_valid); end
        advance();
        mem_drive(); #1; model_eval();
        n_cmp++; if (inst_valid !== 1'b1 || inst_out !== 32'hDEAD_BEEF || inst_pc !== 32'h0) begin
            n_fail++; $display("FAIL nobypass_next_cycle: valid=%b out=%h pc=%h want 1/deadbeef/0", inst_valid, inst_out, inst_pc);
        end
        advance();
`endif
    endtask

    // Random consumer, flushes, redirects and memory latency against the model.
    task automatic test_random();
        do_reset();
        mem_lat_min = 1; mem_lat_max = 3; mem_stall = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            inst_ready = 1'($urandom_range(1, 0));
            flush      = ($urandom_range(19, 0) == 0);
            if (flush) pc_value = {$urandom()} & 32'hFFFF_FFFC;
            mem_drive(); #1; model_eval();
            n_cmp++; if (imem_req !== exp_req || need_insert !== exp_req) begin
                n_fail++; $display("FAIL rnd_req[%0d]: req=%b ni=%b want %b", i, imem_req, need_insert, exp_req);
            end
            n_cmp++; if (imem_addr !== pc_value) begin
                n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, imem_addr, pc_value);
            end
            n_cmp++; if (inst_valid !== exp_valid) begin
                n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, inst_valid, exp_valid);
            end
            if (exp_valid) begin
                n_cmp++; if (inst_out !== exp_out || inst_pc !== exp_pc) begin
                    n_fail++; $display("FAIL rnd_head[%0d]: out=%h pc=%h want %h/%h", i, inst_out, inst_pc, exp_out, exp_pc);
                end
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_fill_to_full();
        test_single_pop();
        test_flush();
        test_back_to_back();
        test_bypass();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: instruction address width; matches the PC value width.
REQ-002 Parameter INST_WIDTH, default 32: instruction word width.
REQ-003 Parameter DEPTH, default 4: queue entries; power of two, at least 2.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port pc_value, input, ADDR_WIDTH: current fetch address from the PC stage.
REQ-007 Port need_insert, output, 1: tells the PC stage to advance by one instruction this cycle.
REQ-008 Port imem_req, output, 1: fetch request to instruction memory.
REQ-009 Port imem_addr, output, ADDR_WIDTH: fetch address; equals pc_value.
REQ-010 Port imem_valid, input, 1: a memory response is present this cycle.
REQ-011 Port imem_data, input, INST_WIDTH: response data; responses return in request order, latency 1 or more cycles.
REQ-012 Port flush, input, 1: discard all queued and in-flight instructions.
REQ-013 Port inst_valid, output, 1: the head entry holds a fetched instruction.
REQ-014 Port inst_out, output, INST_WIDTH: head instruction.
REQ-015 Port inst_pc, output, ADDR_WIDTH: address of the head instruction.
REQ-016 Port inst_ready, input, 1: the consumer takes the head this cycle if inst_valid is high.

Function
REQ-017 Storage: DEPTH entries of {pc, inst, filled}; three pointers (head, fill, tail), each with one wrap bit.
REQ-018 Occupancy = tail - head, including entries that are pending fill.
REQ-019 imem_req = !reset && !flush && occupancy < DEPTH.
REQ-020 need_insert = imem_req, combinationally; the PC advances exactly once per request.
REQ-021 On a request: entry[tail].pc <= pc_value; filled <= 0; tail increments at the edge.
REQ-022 On imem_valid with drop_cnt == 0: entry[fill].inst <= imem_data; filled <= 1; fill increments.
REQ-023 inst_valid = (head != fill); inst_out and inst_pc come from entry[head].
REQ-024 Pop when inst_valid && inst_ready: head increments at the edge.
REQ-025 Request, fill and pop in the same cycle are all honoured independently.
REQ-026 A pop in cycle N does not free a slot for a request in cycle N; the freed slot is visible from cycle N+1.
REQ-027 Full (occupancy == DEPTH): imem_req = 0 and need_insert = 0; the PC holds.
REQ-028 Pointers wrap modulo DEPTH; the wrap bit distinguishes full from empty.
REQ-029 Flush, at the edge:
- head, fill and tail reset to 0.
- drop_cnt <= (tail - fill) minus 1 if imem_valid is high that cycle.
- Output inst_valid is forced 0 during the flush cycle.
REQ-030 While drop_cnt > 0, each imem_valid decrements drop_cnt and its data is discarded.
REQ-031 New requests may issue in the cycle after a flush, even while drop_cnt > 0.
REQ-032 imem_valid with no outstanding request is a protocol error; it is ignored and no state changes.

Reset
REQ-033 While reset is asserted: head = fill = tail = 0, drop_cnt = 0, all filled bits = 0, immediately and without a clock.
REQ-034 During reset, need_insert = imem_req = inst_valid = 0; inst_out and inst_pc read 0.
REQ-035 Reset takes effect mid-transaction; in-flight responses arriving after reset are not dropped, and the memory is reset with this block.

Configuration
REQ-036 Macro INST_QUEUE_BYPASS_EN:
- Defined: when head == fill and imem_valid is high with drop_cnt == 0, the response is presented combinationally:
  - inst_valid = 1, inst_out = imem_data, inst_pc = entry[fill].pc.
  - If inst_ready is high, head and fill both increment and no entry is written as filled.
- Undefined: responses always take at least one cycle through storage before inst_valid rises.

Verification
REQ-037 Reset, then idle with memory latency 1 and pc_value stepping 0, 4, 8:
- need_insert high for 4 consecutive cycles, then low (DEPTH 4, inst_ready 0).
- inst_pc sequence is 0, 4, 8, 12.
REQ-038 Full queue, then a single inst_ready pulse:
- Head pops.
- need_insert rises for exactly 1 cycle in the following cycle.
REQ-039 Flush with 2 requests in flight:
- Next two imem_valid responses are discarded.
- The third response fills entry 0 with the post-flush pc_value.
REQ-040 Simultaneous request, fill and pop at occupancy 2: occupancy stays 2 and inst_out advances.
REQ-041 Wrap-around: 9 fetch/pop pairs at DEPTH 4 deliver addresses 0 through 32 in order, with no loss and no duplication.
REQ-042 With INST_QUEUE_BYPASS_EN, empty queue and inst_ready 1: imem_data 0xDEADBEEF appears on inst_out in the same cycle as imem_valid.
